// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and per-beat control fields for alu_pipe.
// Purely declarative: no latency or backpressure of its own.
package alu_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [3:0] OP_PASS_A = 4'h0;
  localparam logic [3:0] OP_INC_A  = 4'h1;
  localparam logic [3:0] OP_DEC_A  = 4'h2;
  localparam logic [3:0] OP_PASS_B = 4'h3;
  localparam logic [3:0] OP_INC_B  = 4'h4;
  localparam logic [3:0] OP_DEC_B  = 4'h5;
  localparam logic [3:0] OP_ADD    = 4'h6;
  localparam logic [3:0] OP_ADC    = 4'h7;
  localparam logic [3:0] OP_NOT_A  = 4'h8;
  localparam logic [3:0] OP_NOT_B  = 4'h9;
  localparam logic [3:0] OP_AND    = 4'hA;
  localparam logic [3:0] OP_OR     = 4'hB;
  localparam logic [3:0] OP_NAND   = 4'hC;
  localparam logic [3:0] OP_NOR    = 4'hD;
  localparam logic [3:0] OP_XOR    = 4'hE;
  localparam logic [3:0] OP_XNOR   = 4'hF;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_ZERO = 1;
  localparam int FLAG_OVF  = 2;
  localparam int NFLAGS    = 3;

  typedef struct packed {
    logic [3:0] sel;
    logic       cin;
    logic       use_acc;
    logic       acc_wr;
  } ctl_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result, carry/borrow and signed overflow for one op.
// Zero latency; no handshake, the caller owns all registers and flow control.
module alu_core import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             ci;
  logic             arith;
  logic             sub;
  logic [WIDTH:0]   sum;

  // Every +1/-1/add op is folded onto one adder; decrement adds all-ones and
  // the inverted carry becomes the borrow.
  always_comb begin
    opa   = a;
    opb   = '0;
    ci    = 1'b0;
    arith = 1'b0;
    sub   = 1'b0;
    y     = '0;
    cout  = 1'b0;
    ovf   = 1'b0;
    case (sel)
      OP_PASS_A: y = a;
      OP_INC_A:  begin arith = 1'b1; ci = 1'b1; end
      OP_DEC_A:  begin arith = 1'b1; sub = 1'b1; opb = '1; end
      OP_PASS_B: y = b;
      OP_INC_B:  begin opa = b; arith = 1'b1; ci = 1'b1; end
      OP_DEC_B:  begin opa = b; arith = 1'b1; sub = 1'b1; opb = '1; end
      OP_ADD:    begin opb = b; arith = 1'b1; end
      OP_ADC:    begin opb = b; arith = 1'b1; ci = cin; end
      OP_NOT_A:  y = ~a;
      OP_NOT_B:  y = ~b;
      OP_AND:    y = a & b;
      OP_OR:     y = a | b;
      OP_NAND:   y = ~(a & b);
      OP_NOR:    y = ~(a | b);
      OP_XOR:    y = a ^ b;
      OP_XNOR:   y = ~(a ^ b);
      default:   y = '0;
    endcase
    sum = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, ci};
    if (arith) begin
      y    = sum[WIDTH-1:0];
      cout = sum[WIDTH] ^ sub;
      ovf  = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with accumulator; 2 cycles accept->out_valid, one op per cycle.
// Backpressure: in_ready drops combinationally when S1 is full and S2 is held.
module alu_pipe import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       sel,
  input  logic             use_acc,
  input  logic             acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             zero,
  output logic             ovf
);

  ctl_t              s1_ctl;
  logic [WIDTH-1:0]  s1_a;
  logic [WIDTH-1:0]  s1_b;
  logic              s1_valid;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  core_a;
  logic [WIDTH-1:0]  core_y;
  logic              core_cout;
  logic              core_ovf;
  logic              s2_adv;
  logic              accept;
  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] flags_nxt;

  assign s2_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_adv;
  assign accept   = in_valid && in_ready;

  // Accumulator is read at S2 time, so it already holds every earlier write.
  assign core_a = s1_ctl.use_acc ? acc : s1_a;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (core_a),
    .b    (s1_b),
    .cin  (s1_ctl.cin),
    .sel  (s1_ctl.sel),
    .y    (core_y),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_comb begin
    flags_nxt            = '0;
    flags_nxt[FLAG_COUT] = core_cout;
    flags_nxt[FLAG_ZERO] = (core_y == '0);
    flags_nxt[FLAG_OVF]  = core_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctl   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_ctl   <= '{sel: sel, cin: cin, use_acc: use_acc, acc_wr: acc_wr};
      s1_a     <= a;
      s1_b     <= b;
    end else if (s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      flags     <= '0;
      acc       <= '0;
    end else if (s2_adv) begin
      out_valid <= 1'b1;
      y         <= core_y;
      flags     <= flags_nxt;
      if (s1_ctl.acc_wr) begin
        acc <= core_y;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign cout = flags[FLAG_COUT];
  assign zero = flags[FLAG_ZERO];
  assign ovf  = flags[FLAG_OVF];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: 8-bit and 16-bit instances share one stimulus stream,
// each checked against an integer-arithmetic reference model.
module tb_alu_pipe;
  import alu_pkg::*;

  typedef struct {
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        use_acc;
    logic        acc_wr;
  } beat_t;

  typedef struct {
    logic [15:0] y;
    logic        co;
    logic        z;
    logic        ov;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [3:0]  sel;
  logic        use_acc;
  logic        acc_wr;
  logic        out_ready;

  logic        ir8, ov8, co8, z8, of8;
  logic [7:0]  y8;
  logic        ir16, ov16, co16, z16, of16;
  logic [15:0] y16;

  int checks = 0;
  int errors = 0;
  int macc8  = 0;
  int macc16 = 0;

  beat_t stim_q[$];
  res_t  exp8[$];
  res_t  exp16[$];

  alu_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .cin(cin), .sel(sel), .use_acc(use_acc),
    .acc_wr(acc_wr), .out_valid(ov8), .out_ready(out_ready), .y(y8),
    .cout(co8), .zero(z8), .ovf(of8)
  );

  alu_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a), .b(b), .cin(cin), .sel(sel), .use_acc(use_acc),
    .acc_wr(acc_wr), .out_valid(ov16), .out_ready(out_ready), .y(y16),
    .cout(co16), .zero(z16), .ovf(of16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int sgn(input int w, input int x);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  // Reference: exact integer result; carry/borrow means "left the unsigned
  // range", overflow means "left the signed range".
  function automatic res_t model(input int w, input beat_t bt, input int acc);
    int m, h, av, bv, r, sr;
    bit arith;
    res_t o;
    m = (1 << w) - 1;
    h = 1 << (w - 1);
    av = bt.use_acc ? acc : (int'(bt.a) & m);
    bv = int'(bt.b) & m;
    arith = 1'b1;
    sr = 0;
    r = 0;
    case (bt.sel)
      4'h0: begin r = av; arith = 1'b0; end
      4'h1: begin r = av + 1; sr = sgn(w, av) + 1; end
      4'h2: begin r = av - 1; sr = sgn(w, av) - 1; end
      4'h3: begin r = bv; arith = 1'b0; end
      4'h4: begin r = bv + 1; sr = sgn(w, bv) + 1; end
      4'h5: begin r = bv - 1; sr = sgn(w, bv) - 1; end
      4'h6: begin r = av + bv; sr = sgn(w, av) + sgn(w, bv); end
      4'h7: begin r = av + bv + int'(bt.cin); sr = sgn(w, av) + sgn(w, bv) + int'(bt.cin); end
      4'h8: begin r = ~av; arith = 1'b0; end
      4'h9: begin r = ~bv; arith = 1'b0; end
      4'hA: begin r = av & bv; arith = 1'b0; end
      4'hB: begin r = av | bv; arith = 1'b0; end
      4'hC: begin r = ~(av & bv); arith = 1'b0; end
      4'hD: begin r = ~(av | bv); arith = 1'b0; end
      4'hE: begin r = av ^ bv; arith = 1'b0; end
      default: begin r = ~(av ^ bv); arith = 1'b0; end
    endcase
    o.y  = 16'(r & m);
    o.co = arith && (r < 0 || r > m);
    o.ov = arith && (sr > h - 1 || sr < -h);
    o.z  = (o.y == 16'h0);
    return o;
  endfunction

  function automatic beat_t rand_beat(input bit acc_en);
    beat_t bt;
    bt.sel     = 4'($urandom);
    bt.a       = 16'($urandom);
    bt.b       = 16'($urandom);
    bt.cin     = 1'($urandom);
    bt.use_acc = acc_en ? 1'($urandom) : 1'b0;
    bt.acc_wr  = acc_en ? 1'($urandom) : 1'b0;
    return bt;
  endfunction

  function automatic beat_t mk(input logic [3:0] s, input int av, input int bv,
                               input bit c, input bit ua, input bit aw);
    beat_t bt;
    bt.sel = s; bt.a = 16'(av); bt.b = 16'(bv);
    bt.cin = c; bt.use_acc = ua; bt.acc_wr = aw;
    return bt;
  endfunction

  task automatic drive_head();
    if (stim_q.size() > 0) begin
      in_valid = 1'b1;
      sel = stim_q[0].sel; a = stim_q[0].a; b = stim_q[0].b;
      cin = stim_q[0].cin; use_acc = stim_q[0].use_acc; acc_wr = stim_q[0].acc_wr;
    end else begin
      in_valid = 1'b0;
      sel = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
      cin = 1'($urandom); use_acc = 1'($urandom); acc_wr = 1'($urandom);
    end
  endtask

  task automatic accept_beat();
    beat_t bt;
    res_t r8, r16;
    bt = stim_q.pop_front();
    r8  = model(8, bt, macc8);
    r16 = model(16, bt, macc16);
    exp8.push_back(r8);
    exp16.push_back(r16);
    if (bt.acc_wr) begin
      macc8  = int'(r8.y);
      macc16 = int'(r16.y);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    macc8 = 0; macc16 = 0;
    stim_q.delete(); exp8.delete(); exp16.delete();
  endtask

  task automatic run_stream(input int bp_pct, input int budget);
    int cyc;
    res_t e;
    cyc = 0;
    while ((stim_q.size() > 0 || exp8.size() > 0 || exp16.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      drive_head();
      out_ready = ($urandom_range(99) >= bp_pct);
      #1;
      if (ov8 && out_ready) begin
        checks++;
        if (exp8.size() == 0) begin
          errors++;
          $display("FAIL stream8_unexpected y=%h", y8);
        end else begin
          e = exp8.pop_front();
          if ({y8, co8, z8, of8} !== {e.y[7:0], e.co, e.z, e.ov}) begin
            errors++;
            $display("FAIL stream8 got y=%h c=%b z=%b v=%b want y=%h c=%b z=%b v=%b",
                     y8, co8, z8, of8, e.y[7:0], e.co, e.z, e.ov);
          end
        end
      end
      if (ov16 && out_ready) begin
        checks++;
        if (exp16.size() == 0) begin
          errors++;
          $display("FAIL stream16_unexpected y=%h", y16);
        end else begin
          e = exp16.pop_front();
          if ({y16, co16, z16, of16} !== {e.y, e.co, e.z, e.ov}) begin
            errors++;
            $display("FAIL stream16 got y=%h c=%b z=%b v=%b want y=%h c=%b z=%b v=%b",
                     y16, co16, z16, of16, e.y, e.co, e.z, e.ov);
          end
        end
      end
      if (in_valid && ir8) accept_beat();
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (stim_q.size() != 0 || exp8.size() != 0 || exp16.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout pending stim=%0d exp8=%0d exp16=%0d want 0",
               stim_q.size(), exp8.size(), exp16.size());
      stim_q.delete(); exp8.delete(); exp16.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sel = '0; use_acc = 1'b0; acc_wr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ov8, y8, co8, z8, of8, ir8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset8 got v=%b y=%h c=%b z=%b o=%b r=%b want 0/00/0/0/0/1",
               ov8, y8, co8, z8, of8, ir8);
    end
    checks++;
    if ({ov16, y16, co16, z16, of16, ir16} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset16 got v=%b y=%h r=%b want 0/0000/1", ov16, y16, ir16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset got out_valid=%b in_ready=%b want 0/1", ov8, ir8);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ts [0:3] = '{OP_ADC, OP_INC_A, OP_DEC_A, OP_DEC_A};
    logic [7:0] ta [0:3] = '{8'hF0, 8'h7F, 8'h00, 8'h80};
    logic [7:0] tb [0:3] = '{8'h0F, 8'h00, 8'h00, 8'h00};
    logic [7:0] ey [0:3] = '{8'h00, 8'h80, 8'hFF, 8'h7F};
    logic [2:0] ef [0:3] = '{3'b110, 3'b001, 3'b100, 3'b001};  // {cout, zero, ovf}
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; sel = ts[i]; a = {8'h00, ta[i]}; b = {8'h00, tb[i]};
      cin = 1'b1; use_acc = 1'b0; acc_wr = 1'b0; out_ready = 1'b1;
      #1;
      checks++;
      if (ir8 !== 1'b1) begin
        errors++;
        $display("FAIL directed_ready[%0d] got %b want 1", i, ir8);
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      checks++;
      if (ov8 !== 1'b0) begin
        errors++;
        $display("FAIL directed_early[%0d] got out_valid=%b want 0", i, ov8);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({ov8, y8, co8, z8, of8} !== {1'b1, ey[i], ef[i]}) begin
        errors++;
        $display("FAIL directed[%0d] got v=%b y=%h czo=%b%b%b want 1 y=%h czo=%b",
                 i, ov8, y8, co8, z8, of8, ey[i], ef[i]);
      end
    end
  endtask

  task automatic test_accumulate();
    int bv [0:3] = '{5, 7, 9, 0};
    int ey [0:6] = '{0, 0, 5, 12, 21, 21, 0};
    bit ev [0:6] = '{0, 0, 1, 1, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 4) begin
        in_valid = 1'b1; sel = (i < 3) ? OP_ADD : OP_PASS_A;
        a = 16'($urandom); b = 16'(bv[i]); cin = 1'b0;
        use_acc = 1'b1; acc_wr = (i < 3);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (ov8 !== ev[i] || (ev[i] && y8 !== 8'(ey[i]))) begin
        errors++;
        $display("FAIL accum8[%0d] got v=%b y=%0d want v=%b y=%0d", i, ov8, y8, ev[i], ey[i]);
      end
      checks++;
      if (ov16 !== ev[i] || (ev[i] && y16 !== 16'(ey[i]))) begin
        errors++;
        $display("FAIL accum16[%0d] got v=%b y=%0d want v=%b y=%0d", i, ov16, y16, ev[i], ey[i]);
      end
    end
    macc8 = 21; macc16 = 21;
  endtask

  task automatic test_logic_sweep();
    for (int s = 8; s < 16; s++) stim_q.push_back(mk(4'(s), 16'hCCCC, 16'hAAAA, 1'b1, 1'b0, 1'b0));
    run_stream(0, 40);
  endtask

  task automatic test_backpressure();
    int n_acc;
    logic [10:0] hold;
    n_acc = 0;
    hold = '0;
    for (int i = 0; i < 3; i++) stim_q.push_back(rand_beat(1'b1));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_head();
      out_ready = 1'b0;
      #1;
      if (i == 2) begin
        hold = {y8, co8, z8, of8};
        checks++;
        if (ov8 !== 1'b1 || ir8 !== 1'b0) begin
          errors++;
          $display("FAIL bp_stall got out_valid=%b in_ready=%b want 1/0", ov8, ir8);
        end
      end
      if (i == 3) begin
        checks++;
        if ({y8, co8, z8, of8} !== hold || ir8 !== 1'b0) begin
          errors++;
          $display("FAIL bp_hold got %h r=%b want %h r=0", {y8, co8, z8, of8}, ir8, hold);
        end
      end
      if (in_valid && ir8) begin
        accept_beat();
        n_acc++;
      end
    end
    checks++;
    if (n_acc != 2) begin
      errors++;
      $display("FAIL bp_accepts got %0d want 2", n_acc);
    end
    run_stream(0, 40);
  endtask

  task automatic test_reset_mid_stall();
    @(negedge clk);
    in_valid = 1'b1; sel = OP_ADD; a = 16'h1234; b = 16'h0FFF;
    cin = 1'b0; use_acc = 1'b0; acc_wr = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    sel = OP_DEC_A; use_acc = 1'b1; acc_wr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b1 || ov16 !== 1'b1) begin
      errors++;
      $display("FAIL mid_stall_setup got v8=%b v16=%b want 1/1", ov8, ov16);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov8, y8, co8, z8, of8, ir8} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset8 got v=%b y=%h c=%b z=%b o=%b r=%b want 0/00/0/0/0/1",
               ov8, y8, co8, z8, of8, ir8);
    end
    checks++;
    if ({ov16, y16, co16, z16, of16, ir16} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset16 got v=%b y=%h c=%b z=%b o=%b r=%b want 0/0000/0/0/0/1",
               ov16, y16, co16, z16, of16, ir16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    macc8 = 0; macc16 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (ov8 !== 1'b0 || ov16 !== 1'b0) begin
        errors++;
        $display("FAIL stale_result[%0d] got v8=%b v16=%b want 0/0", i, ov8, ov16);
      end
    end
    stim_q.push_back(mk(OP_PASS_A, 16'h5A5A, 0, 1'b0, 1'b1, 1'b0));
    stim_q.push_back(mk(OP_DEC_A, 16'h5A5A, 0, 1'b0, 1'b1, 1'b0));
    stim_q.push_back(mk(OP_ADD, 16'h5A5A, 3, 1'b0, 1'b1, 1'b0));
    run_stream(0, 40);
  endtask

  task automatic test_random();
    for (int i = 0; i < 250; i++) stim_q.push_back(rand_beat(1'b1));
    run_stream(35, 3000);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) stim_q.push_back(rand_beat(1'b1));
    run_stream(0, 200);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_accumulate();
    test_logic_sweep();
    test_backpressure();
    test_reset_mid_stall();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
